// File: rtl/uart_pkg.sv
// Shared UART definitions: frame format, FSM state encoding and baud divisor.
// Both the transmitter and the receiver use the divisor helper.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    function automatic int calc_bit_cycles(input int clock_frequency, input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO between the host handshake and the serialiser.
// Read data is presented combinationally from the head slot.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DATA_BITS
) (
    input  logic             clockIN,
    input  logic             nRxResetIN,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] COUNT_FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (count_q == COUNT_FULL);
    assign empty_o   = (count_q == {(PW+1){1'b0}});
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;
    assign data_o    = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clockIN or negedge nRxResetIN) begin
        if (!nRxResetIN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {(PW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: byte FIFO feeding a start/data/stop serialiser.
// The line register is loaded from next-state so txOUT changes on the same edge as the FSM.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE       = 9600,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clockIN,
    input  logic       nRxResetIN,
    input  logic [7:0] txDataIN,
    input  logic       txValidIN,
    output logic       txReadyOUT,
    output logic       txOUT,
    output logic       txIdleOUT
);

    localparam int BIT_CYCLES = calc_bit_cycles(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int CW         = (BIT_CYCLES < 2) ? 1 : $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    if (BIT_CYCLES < 2) begin : g_bad_baud
        $error("uart_tx: CLOCK_FREQUENCY / BAUD_RATE must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx: FIFO_DEPTH must be a power of two and at least 2");
    end
    if (STOP_BITS != 1 || DATA_BITS != 8) begin : g_bad_frame
        $error("uart_tx: only 8 data bits with one stop bit are supported");
    end

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end_s;
    logic          fifo_push_s;
    logic          fifo_pop_s;
    logic [7:0]    fifo_data_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;

    assign txReadyOUT  = ~fifo_full_s;
    assign fifo_push_s = txValidIN & ~fifo_full_s;
    assign txIdleOUT   = (state_q == ST_IDLE) & fifo_empty_s;
    assign txOUT       = tx_q;
    assign bit_end_s   = (baud_q == BAUD_LAST);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clockIN    (clockIN),
        .nRxResetIN (nRxResetIN),
        .push_i     (fifo_push_s),
        .data_i     (txDataIN),
        .pop_i      (fifo_pop_s),
        .data_o     (fifo_data_s),
        .full_o     (fifo_full_s),
        .empty_o    (fifo_empty_s)
    );

    // Frame sequencing: the stop bit chains straight into the next start bit when a byte waits.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        fifo_pop_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = {CW{1'b0}};
                bit_d  = 3'd0;
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    shift_d    = fifo_data_s;
                    state_d    = ST_START;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    baud_d  = {CW{1'b0}};
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    baud_d  = baud_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    baud_d  = {CW{1'b0}};
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d  = baud_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    baud_d = {CW{1'b0}};
                    if (!fifo_empty_s) begin
                        fifo_pop_s = 1'b1;
                        shift_d    = fifo_data_s;
                        state_d    = ST_START;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                baud_d  = {CW{1'b0}};
                bit_d   = 3'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level for the state being entered.
    always_comb begin
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // State registers; reset drives the line high immediately.
    always_ff @(posedge clockIN or negedge nRxResetIN) begin
        if (!nRxResetIN) begin
            state_q <= ST_IDLE;
            baud_q  <= {CW{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule
